// File: rtl/peri_uart_rx_pkg.sv
// rtl/peri_uart_rx_pkg.sv - shared types and flag positions for the UART receiver
// Contents:
//   uart_rx_state_t  receive FSM states
//   RX_*_BIT         bit positions of the flags in the control/status word
package peri_uart_rx_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } uart_rx_state_t;

  localparam int unsigned RX_VALID_BIT     = 0;
  localparam int unsigned RX_OVERRUN_BIT   = 1;
  localparam int unsigned RX_FRAME_ERR_BIT = 2;

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 deserialiser: synchroniser, receive FSM, shift register
// Ports:
//   clk_i      system clock
//   reset_i    synchronous active-high reset
//   uart_rx_i  asynchronous serial line, idle high
//   byte_o     assembled byte, meaningful while done_o is high
//   done_o     one-cycle pulse: frame with good stop bit
//   ferr_o     one-cycle pulse: stop bit sampled low
module uart_rx_core
  import peri_uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1042
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       uart_rx_i,
  output logic [7:0] byte_o,
  output logic       done_o,
  output logic       ferr_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic           sync1_q, sync2_q;
  logic           rx_s;
  uart_rx_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;

  assign rx_s = sync2_q;

  // Synchroniser resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      sync1_q   <= uart_rx_i;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = RX_START;
      end
      RX_START: begin
        // Re-check half a bit in so a short low pulse is rejected as a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        // Leaving mid-stop-bit lets a start bit follow with no idle gap.
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_BREAK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_BREAK: begin
        // A held-low line must return high before another start is accepted.
        cnt_d = '0;
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    done_o = 1'b0;
    ferr_o = 1'b0;
    if (state_q == RX_STOP && cnt_q == FULL_M1) begin
      done_o = rx_s;
      ferr_o = !rx_s;
    end
  end

  assign byte_o = shift_q;

endmodule

// File: rtl/peri_uart_rx.sv
// rtl/peri_uart_rx.sv - memory-mapped UART receiver with holding register and W1C flags
// Ports:
//   clk_i              system clock
//   reset_i            synchronous active-high reset
//   uart_rx_i          serial line from the board pin
//   data_i             processor write data
//   we_ctrl_uart_rx_i  write strobe for the control/status register
//   data_out_o         {24'b0, rx_byte}
//   data_out_ctrl_o    {29'b0, frame_err, overrun, valid}
module peri_uart_rx
  import peri_uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1042
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        uart_rx_i,
  input  logic [31:0] data_i,
  input  logic        we_ctrl_uart_rx_i,
  output logic [31:0] data_out_o,
  output logic [31:0] data_out_ctrl_o
);

  logic [7:0] core_byte;
  logic       core_done, core_ferr;

  logic [7:0] rx_byte_q, rx_byte_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;
  logic       ferr_q, ferr_d;
  logic       unused_data;

  assign unused_data = ^data_i[31:3];

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .uart_rx_i(uart_rx_i),
    .byte_o   (core_byte),
    .done_o   (core_done),
    .ferr_o   (core_ferr)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_byte_q <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_byte_q <= rx_byte_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

  // Software clears are applied first so a hardware set in the same cycle wins.
  always_comb begin
    rx_byte_d = rx_byte_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    ferr_d    = ferr_q;
    if (we_ctrl_uart_rx_i) begin
      if (data_i[RX_VALID_BIT])     valid_d   = 1'b0;
      if (data_i[RX_OVERRUN_BIT])   overrun_d = 1'b0;
      if (data_i[RX_FRAME_ERR_BIT]) ferr_d    = 1'b0;
    end
    if (core_done) begin
      rx_byte_d = core_byte;
      valid_d   = 1'b1;
      if (valid_q) overrun_d = 1'b1;
    end
    if (core_ferr) ferr_d = 1'b1;
  end

  always_comb begin
    data_out_ctrl_o                   = '0;
    data_out_ctrl_o[RX_VALID_BIT]     = valid_q;
    data_out_ctrl_o[RX_OVERRUN_BIT]   = overrun_q;
    data_out_ctrl_o[RX_FRAME_ERR_BIT] = ferr_q;
  end

  assign data_out_o = {24'b0, rx_byte_q};

endmodule
